// File: rtl/mem_access_unit.sv
// Memory-stage access unit: decodes EXM load/store, runs a single-outstanding
// request/response handshake with the data cache, and returns the extended load value.
module mem_access_unit (
    input  logic         clk,
    input  logic         resetn,
    input  logic [102:0] es_to_ms_bus,
    output logic [33:0]  ms_to_es_bus,
    input  logic         ws_ready,
    output logic         data_req,
    output logic         data_wr,
    output logic [1:0]   data_size,
    output logic [31:0]  data_addr,
    output logic [3:0]   data_wstrb,
    output logic [31:0]  data_wdata,
    input  logic         data_addr_ok,
    input  logic         data_data_ok,
    input  logic [31:0]  data_rdata
);
    localparam int unsigned DW = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [DW-1:0] bus_addr, bus_wdata, bus_pc;
    logic          bus_uns, bus_we, bus_re;
    logic [3:0]    bus_bw;

    assign bus_addr  = es_to_ms_bus[102:71];
    assign bus_uns   = es_to_ms_bus[70];
    assign bus_we    = es_to_ms_bus[69];
    assign bus_re    = es_to_ms_bus[68];
    assign bus_bw    = es_to_ms_bus[67:64];
    assign bus_wdata = es_to_ms_bus[63:32];
    assign bus_pc    = es_to_ms_bus[31:0];

    logic unused_pc;
    assign unused_pc = ^bus_pc;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          wr_q, wr_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          uns_q, uns_d;
    logic [DW-1:0] result_q, result_d;

    // Width decode and alignment check on the live bus
    logic          is_byte, is_half, is_word, access, excp_ale;
    logic [1:0]    size_c;
    logic [3:0]    strb_c;
    logic [DW-1:0] wrep_c;

    always_comb begin
        is_byte  = (bus_bw == 4'b0001);
        is_half  = (bus_bw == 4'b0010);
        is_word  = ~is_byte & ~is_half;
        access   = bus_we | bus_re;
        excp_ale = access & ((is_half & bus_addr[0]) | (is_word & (bus_addr[1:0] != 2'b00)));
        size_c   = is_byte ? SZ_BYTE : (is_half ? SZ_HALF : SZ_WORD);
        if (is_byte) begin
            strb_c = 4'b0001 << bus_addr[1:0];
            wrep_c = {4{bus_wdata[7:0]}};
        end else if (is_half) begin
            strb_c = bus_addr[1] ? 4'b1100 : 4'b0011;
            wrep_c = {2{bus_wdata[15:0]}};
        end else begin
            strb_c = 4'b1111;
            wrep_c = bus_wdata;
        end
    end

    // Load lane extraction from the captured access; stores return zero
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_val;

    always_comb begin
        ld_byte = 8'(data_rdata >> {addr_q[1:0], 3'b000});
        ld_half = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (size_q)
            SZ_BYTE: ld_val = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_val = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = data_rdata;
        endcase
        if (wr_q) ld_val = '0;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        wr_d     = wr_q;
        wstrb_d  = wstrb_q;
        wdata_d  = wdata_q;
        uns_d    = uns_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (access && !excp_ale) begin
                    state_d = S_REQ;
                    addr_d  = bus_addr;
                    size_d  = size_c;
                    wr_d    = bus_we;
                    wstrb_d = bus_we ? strb_c : 4'b0000;
                    wdata_d = wrep_c;
                    uns_d   = bus_uns;
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d  = S_DONE;
                        result_d = ld_val;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_d  = S_DONE;
                    result_d = ld_val;
                end
            end
            default: begin
                if (ws_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            wr_q     <= 1'b0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            uns_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            wr_q     <= wr_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            uns_q    <= uns_d;
            result_q <= result_d;
        end
    end

    logic          dcache_ok;
    logic [DW-1:0] mem_result;

    assign dcache_ok  = ((state_q == S_IDLE) && (!access || excp_ale)) || (state_q == S_DONE);
    assign mem_result = (state_q == S_DONE) ? result_q : '0;

    assign ms_to_es_bus = {excp_ale, dcache_ok, mem_result};
    assign data_req     = (state_q == S_REQ);
    assign data_wr      = wr_q;
    assign data_size    = size_q;
    assign data_addr    = addr_q;
    assign data_wstrb   = wstrb_q;
    assign data_wdata   = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: reset, no-access, aligned
// loads/stores, misalignment, cache back-pressure, and reset mid-access.
module tb_mem_access_unit;
    logic         clk = 1'b0;
    logic         resetn;
    logic [102:0] es_to_ms_bus;
    logic [33:0]  ms_to_es_bus;
    logic         ws_ready;
    logic         data_req, data_wr;
    logic [1:0]   data_size;
    logic [31:0]  data_addr, data_wdata;
    logic [3:0]   data_wstrb;
    logic         data_addr_ok, data_data_ok;
    logic [31:0]  data_rdata;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    int hs_base;

    mem_access_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .es_to_ms_bus (es_to_ms_bus),
        .ms_to_es_bus (ms_to_es_bus),
        .ws_ready     (ws_ready),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (resetn && data_req && data_addr_ok) hs_cnt <= hs_cnt + 1;
    end

    logic        excp_ale, dcache_ok;
    logic [31:0] mem_result;
    assign excp_ale   = ms_to_es_bus[33];
    assign dcache_ok  = ms_to_es_bus[32];
    assign mem_result = ms_to_es_bus[31:0];

    function automatic logic [102:0] mk(input logic [31:0] addr, input logic uns,
                                        input logic we, input logic re,
                                        input logic [3:0] bw, input logic [31:0] wd);
        return {addr, uns, we, re, bw, wd, 32'h1C00_0040};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn       = 1'b0;
        es_to_ms_bus = '0;
        ws_ready     = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        tick(); tick();
        #1;
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_bus_hi", 32'({excp_ale, dcache_ok}), 32'b01);
        chk("rst_result", mem_result, 32'h0);
        chk("rst_addr", data_addr, 32'h0);

        // No access
        resetn = 1'b1;
        tick();
        es_to_ms_bus = mk(32'h0000_1234, 1'b0, 1'b0, 1'b0, 4'b0100, 32'h0);
        #1;
        chk("noacc_hi", 32'({excp_ale, dcache_ok}), 32'b01);
        chk("noacc_res", mem_result, 32'h0);
        chk("noacc_req", 32'(data_req), 32'd0);

        // Signed half load, one-cycle addr_ok then data_ok
        es_to_ms_bus = mk(32'h0000_1002, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h0);
        #1;
        chk("lh_idle_ok", 32'(dcache_ok), 32'd0);
        tick();
        chk("lh_req", 32'(data_req), 32'd1);
        chk("lh_size", 32'(data_size), 32'd1);
        chk("lh_wstrb", 32'(data_wstrb), 32'd0);
        chk("lh_wr", 32'(data_wr), 32'd0);
        chk("lh_addr", data_addr, 32'h0000_1002);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("lh_wait_req", 32'(data_req), 32'd0);
        chk("lh_wait_ok", 32'(dcache_ok), 32'd0);
        data_data_ok = 1'b1;
        data_rdata   = 32'h8001_1234;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        es_to_ms_bus = mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, 4'b0100, 32'h0);
        #1;
        chk("lh_done_ok", 32'(dcache_ok), 32'd1);
        chk("lh_done_res", mem_result, 32'hFFFF_8001);
        ws_ready = 1'b1;
        tick();
        ws_ready = 1'b0;
        chk("lh_idle_res", mem_result, 32'h0);

        // Byte store, addr_ok and data_ok together: minimum latency
        es_to_ms_bus = mk(32'h0000_2003, 1'b0, 1'b1, 1'b0, 4'b0001, 32'h0000_00AB);
        #1;
        chk("sb_c0_ok", 32'(dcache_ok), 32'd0);
        tick();
        es_to_ms_bus = mk(32'h0000_2000, 1'b1, 1'b1, 1'b0, 4'b0100, 32'h1234_5678);
        #1;
        chk("sb_wstrb", 32'(data_wstrb), 32'h8);
        chk("sb_wdata", data_wdata, 32'hABAB_ABAB);
        chk("sb_wr", 32'(data_wr), 32'd1);
        chk("sb_size", 32'(data_size), 32'd0);
        chk("sb_c1_ok", 32'(dcache_ok), 32'd0);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hFFFF_FFFF;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        chk("sb_c2_ok", 32'(dcache_ok), 32'd1);
        chk("sb_c2_res", mem_result, 32'h0);
        ws_ready = 1'b1;
        es_to_ms_bus = '0;
        tick();
        ws_ready = 1'b0;

        // Misaligned word load, then misaligned half
        hs_base = hs_cnt;
        es_to_ms_bus = mk(32'h0000_3002, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h0);
        #1;
        chk("ale_hi", 32'({excp_ale, dcache_ok}), 32'b11);
        chk("ale_req0", 32'(data_req), 32'd0);
        tick();
        chk("ale_req1", 32'(data_req), 32'd0);
        chk("ale_hi1", 32'({excp_ale, dcache_ok}), 32'b11);
        tick();
        chk("ale_req2", 32'(data_req), 32'd0);
        es_to_ms_bus = mk(32'h0000_1001, 1'b0, 1'b1, 1'b0, 4'b0010, 32'h0);
        #1;
        chk("ale_half", 32'({excp_ale, dcache_ok}), 32'b11);
        tick();
        chk("ale_hs", 32'(hs_cnt - hs_base), 32'd0);

        // Word load with addr_ok withheld 3 cycles and ws_ready withheld 2 cycles
        hs_base = hs_cnt;
        es_to_ms_bus = mk(32'h0000_4000, 1'b1, 1'b0, 1'b1, 4'b0100, 32'h0);
        tick();
        es_to_ms_bus = mk(32'h0000_4444, 1'b0, 1'b1, 1'b0, 4'b0001, 32'h5555_5555);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_req_hold", 32'(data_req), 32'd1);
            chk("bp_addr_hold", data_addr, 32'h0000_4000);
            chk("bp_wr_hold", 32'(data_wr), 32'd0);
            tick();
        end
        data_addr_ok = 1'b1;
        #1;
        chk("bp_req4", 32'(data_req), 32'd1);
        chk("bp_size4", 32'(data_size), 32'd2);
        tick();
        data_addr_ok = 1'b0;
        chk("bp_wait_req", 32'(data_req), 32'd0);
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        tick();
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        for (int i = 0; i < 3; i++) begin
            ws_ready = (i == 2);
            #1;
            chk("bp_done_ok", 32'(dcache_ok), 32'd1);
            chk("bp_done_res", mem_result, 32'hDEAD_BEEF);
            chk("bp_done_req", 32'(data_req), 32'd0);
            tick();
        end
        ws_ready = 1'b0;
        es_to_ms_bus = '0;
        #1;
        chk("bp_idle_res", mem_result, 32'h0);
        chk("bp_hs", 32'(hs_cnt - hs_base), 32'd1);

        // Reset while in WAIT, then a fresh signed byte load
        es_to_ms_bus = mk(32'h0000_5001, 1'b1, 1'b0, 1'b1, 4'b0001, 32'h0);
        tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("rw_wait_req", 32'(data_req), 32'd0);
        chk("rw_wait_ok", 32'(dcache_ok), 32'd0);
        resetn = 1'b0;
        es_to_ms_bus = '0;
        tick();
        chk("rw_req", 32'(data_req), 32'd0);
        chk("rw_res", mem_result, 32'h0);
        chk("rw_idle_ok", 32'(dcache_ok), 32'd1);
        chk("rw_addr", data_addr, 32'h0);
        resetn = 1'b1;
        es_to_ms_bus = mk(32'h0000_5001, 1'b0, 1'b0, 1'b1, 4'b0001, 32'h0);
        tick();
        chk("rw_new_req", 32'(data_req), 32'd1);
        chk("rw_new_addr", data_addr, 32'h0000_5001);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h0000_8000;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        chk("rw_new_ok", 32'(dcache_ok), 32'd1);
        chk("rw_new_res", mem_result, 32'hFFFF_FF80);
        ws_ready = 1'b1;
        es_to_ms_bus = '0;
        tick();
        ws_ready = 1'b0;
        chk("rw_end_res", mem_result, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Decided: one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetn  input  1  synchronous active-low reset.
REQ-004 es_to_ms_bus  input  103  {addr[31:0], is_unsigned, mem_we, mem_re, bit_width[3:0], wdata[31:0], pc[31:0]}, MSB first.
REQ-005 ms_to_es_bus  output  34  {excp_ale, dcache_ok, mem_result[31:0]}, MSB first.
REQ-006 ws_ready  input  1  writeback accepts the EXM instruction this cycle.
REQ-007 data_req  output  1  request valid toward data cache.
REQ-008 data_wr  output  1  1 = store, 0 = load.
REQ-009 data_size  output  2  0 = byte, 1 = half, 2 = word.
REQ-010 data_addr  output  32  byte address, passed unmodified.
REQ-011 data_wstrb  output  4  byte enables (stores only; 0 for loads).
REQ-012 data_wdata  output  32  lane-replicated store data.
REQ-013 data_addr_ok  input  1  cache accepted the request this cycle.
REQ-014 data_data_ok  input  1  cache completed the access this cycle.
REQ-015 data_rdata  input  32  raw load word, valid with data_data_ok.

Function
REQ-016 Width decode: bit_width 4'b0001 = byte, 4'b0010 = half; any other value = word.
REQ-017 access = mem_we | mem_re; mem_we wins if both are set.
REQ-018 excp_ale is combinational: access & ((half & addr[0]) | (word & addr[1:0]!=0)).
REQ-019 FSM states: IDLE, REQ, WAIT, DONE.
REQ-020 IDLE: access & ~excp_ale -> REQ next cycle; the unit captures addr, size, wr, wstrb, wdata, is_unsigned into internal registers.
REQ-021 REQ: data_req=1 with the captured fields; data_addr_ok=1 -> WAIT; otherwise stay in REQ with fields held stable.
REQ-022 WAIT: data_data_ok=1 -> DONE, and the unit latches the extended load value; otherwise stay in WAIT. data_req=0.
REQ-023 data_data_ok arriving in the same cycle as data_addr_ok in REQ -> DONE directly, and the unit latches the data.
REQ-024 DONE: dcache_ok=1 and mem_result = latched value; ws_ready=1 -> IDLE; otherwise hold DONE and do not reissue.
REQ-025 dcache_ok is combinational: 1 in IDLE when ~access or excp_ale; 1 in DONE; 0 otherwise.
REQ-026 mem_result = 0 in every state except DONE; for stores, mem_result = 0 in DONE.
REQ-027 Store strobes: byte 4'b0001<<addr[1:0]; half addr[1] ? 4'b1100 : 4'b0011; word 4'b1111.
REQ-028 Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-029 Load extract: byte lane = addr[1:0], half lane = addr[1]; zero-extend if is_unsigned, else sign-extend; word passes through.
REQ-030 Misaligned access issues no request, stays in IDLE, and returns excp_ale=1, dcache_ok=1 in the same cycle.
REQ-031 Bus inputs changing while in REQ/WAIT/DONE are ignored; captured values govern the access.
REQ-032 Minimum access latency: request seen in cycle 0, dcache_ok=1 in cycle 2 (addr_ok and data_ok both in cycle 1).
REQ-033 At most one outstanding cache request.

Reset
REQ-034 resetn=0 at any edge, including mid-access: state -> IDLE; data_req=0; captured registers and latched result -> 0.
REQ-035 During and after reset: ms_to_es_bus = {excp_ale comb., dcache_ok comb., 32'h0}; the unit does not wait for a pending data_ok. The cache is reset by the same resetn.

Verification
REQ-036 No access (mem_we=mem_re=0) -> dcache_ok=1, excp_ale=0, mem_result=0, data_req=0 in the same cycle.
REQ-037 Load half signed, addr=32'h1002, rdata=32'h8001_1234, addr_ok and data_ok 1 cycle each -> data_size=1, wstrb=0, mem_result=32'hFFFF_8001 in DONE.
REQ-038 Store byte, addr=32'h2003, wdata=32'h0000_00AB -> data_wstrb=4'b1000, data_wdata=32'hABAB_ABAB, data_wr=1; dcache_ok only after data_ok.
REQ-039 Load word, addr=32'h3002 -> excp_ale=1, dcache_ok=1, data_req=0 for the whole scenario.
REQ-040 addr_ok withheld 3 cycles, then data_ok, with ws_ready=0 for 2 cycles -> data_req held 4 cycles with stable fields; DONE held 3 cycles; exactly one request issued.
REQ-041 resetn=0 while in WAIT -> IDLE next edge, data_req=0, mem_result=0; a new load after reset completes normally.
